// File: rtl/uni_bus_arbiter.sv
// uni_bus_arbiter: sequencer/arbiter for the shared 8-bit unified bus and
// single-port memory. Each granted access is an address phase followed by a
// data phase. The arbiter owns the bus tri-state enable so that only one
// agent (this block or the memory) drives the bus in any cycle.
// Build option: define UBA_RR_EN for round-robin arbitration; otherwise
// fixed priority (lowest index wins).
module uni_bus_arbiter #(
  parameter int N_REQ = 2,
  parameter int W     = 8
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ-1:0]   we,
  input  logic [N_REQ*W-1:0] addr,
  input  logic [N_REQ*W-1:0] wdata,
  output logic [N_REQ-1:0]   gnt,
  output logic [N_REQ-1:0]   done,
  output logic [W-1:0]       rdata,
  output logic [1:0]         mem_cmd,
  output logic               bus_oe,
  output logic [W-1:0]       bus_out,
  input  logic [W-1:0]       bus_in
);

  localparam int IW = $clog2(N_REQ);

  typedef enum logic [2:0] {
    S_IDLE = 3'b001,
    S_ADDR = 3'b010,
    S_DATA = 3'b100
  } state_t;

  localparam logic [1:0] CMD_IDLE  = 2'b00;
  localparam logic [1:0] CMD_READ  = 2'b01;
  localparam logic [1:0] CMD_WRITE = 2'b10;

  state_t            state;
  state_t            state_nxt;
  logic [N_REQ-1:0]  gnt_q;
  logic              we_q;
  logic [W-1:0]      addr_q;
  logic [W-1:0]      wdata_q;
  logic [N_REQ-1:0]  req_elig;
  logic [IW-1:0]     start_idx;
  logic [IW-1:0]     win_idx;
  logic              win_vld;
  logic [IW:0]       cand;
  logic              grant_now;

`ifdef UBA_RR_EN
  logic [IW-1:0] rr_ptr;

  // Search begins one past the last winner, wrapping at N_REQ.
  always_comb begin
    start_idx = (rr_ptr == IW'(N_REQ - 1)) ? '0 : rr_ptr + 1'b1;
  end

  // Round-robin pointer follows the winner of every grant; reset value makes
  // requester 0 the first to be searched.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rr_ptr <= IW'(N_REQ - 1);
    end else if (grant_now) begin
      rr_ptr <= win_idx;
    end
  end
`else
  assign start_idx = '0;
`endif

  // Winner search; the finishing owner is masked so it cannot win twice in a row.
  always_comb begin
    // NOTE: every variable gets a value before any branch, so no latch can be inferred.
    req_elig = req;
    win_vld  = 1'b0;
    win_idx  = '0;
    cand     = '0;
    if (state == S_DATA) req_elig = req & ~gnt_q;
    for (int i = 0; i < N_REQ; i++) begin
      cand = {1'b0, start_idx} + (IW+1)'(i);
      if (cand >= (IW+1)'(N_REQ)) cand = cand - (IW+1)'(N_REQ);
      if (!win_vld && req_elig[cand[IW-1:0]]) begin
        win_vld = 1'b1;
        win_idx = cand[IW-1:0];
      end
    end
  end

  assign grant_now = win_vld && (state == S_IDLE || state == S_DATA);

  // State register.
  always_ff @(posedge CLK or negedge RST) begin
    // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
    if (!RST) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic: ADDR and DATA last one cycle each; DATA may chain into ADDR.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (win_vld) state_nxt = S_ADDR;
      S_ADDR:  state_nxt = S_DATA;
      S_DATA:  state_nxt = win_vld ? S_ADDR : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Latch the winner's request at the grant edge; later input changes are ignored.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      gnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (grant_now) begin
      gnt_q   <= N_REQ'(1) << win_idx;
      we_q    <= we[win_idx];
      addr_q  <= addr[int'(win_idx)*W +: W];
      wdata_q <= wdata[int'(win_idx)*W +: W];
    end else if (state == S_DATA) begin
      gnt_q   <= '0;
    end
  end

  // Bus, memory command and completion outputs decoded from the registered state.
  always_comb begin
    bus_oe  = 1'b0;
    bus_out = '0;
    mem_cmd = CMD_IDLE;
    done    = '0;
    rdata   = '0;
    unique case (state)
      S_ADDR: begin
        bus_oe  = 1'b1;
        bus_out = addr_q;
        mem_cmd = we_q ? CMD_WRITE : CMD_READ;
      end
      S_DATA: begin
        done = gnt_q;
        if (we_q) begin
          bus_oe  = 1'b1;
          bus_out = wdata_q;
        end else begin
          rdata = bus_in;
        end
      end
      default: ;
    endcase
  end

  assign gnt = gnt_q;

endmodule

// File: tb/tb_uni_bus_arbiter.sv
// Self-checking bench for uni_bus_arbiter: memory model on the unified bus,
// per-requester agents feeding a scoreboard queue, and a negedge monitor that
// pops expectations when done pulses.
module tb_uni_bus_arbiter;
  localparam int N_REQ = 2;
  localparam int W     = 8;

  logic               CLK = 1'b0;
  logic               RST;
  logic [N_REQ-1:0]   req;
  logic [N_REQ-1:0]   we;
  logic [N_REQ*W-1:0] addr;
  logic [N_REQ*W-1:0] wdata;
  logic [N_REQ-1:0]   gnt;
  logic [N_REQ-1:0]   done;
  logic [W-1:0]       rdata;
  logic [1:0]         mem_cmd;
  logic               bus_oe;
  logic [W-1:0]       bus_out;
  logic [W-1:0]       bus_in;

  uni_bus_arbiter #(.N_REQ(N_REQ), .W(W)) dut (
    .CLK(CLK), .RST(RST), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt), .done(done), .rdata(rdata), .mem_cmd(mem_cmd),
    .bus_oe(bus_oe), .bus_out(bus_out), .bus_in(bus_in)
  );

  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- memory model ----------------
  logic [W-1:0] mem     [256];
  logic [W-1:0] ref_mem [256];
  logic         m_rd, m_wr;
  logic [W-1:0] m_addr;

  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      m_rd   <= 1'b0;
      m_wr   <= 1'b0;
      m_addr <= '0;
      for (int j = 0; j < 256; j++) mem[j] <= 8'(j) ^ 8'h99;
    end else begin
      m_rd <= (mem_cmd == 2'b01);
      m_wr <= (mem_cmd == 2'b10);
      if (mem_cmd != 2'b00) m_addr <= bus_out;
      if (m_wr && bus_oe) mem[m_addr] <= bus_out;
    end
  end

  assign bus_in = m_rd ? mem[m_addr] : '0;

  task automatic init_ref();
    for (int j = 0; j < 256; j++) ref_mem[j] = 8'(j) ^ 8'h99;
  endtask

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [7:0]   idx;
    logic         we;
    logic [W-1:0] a;
    logic [W-1:0] d;
  } txn_t;

  txn_t exp_q[$];
  int   done_cyc_q[$];
  int   done_own_q[$];

  logic             addr_seen;
  logic [N_REQ-1:0] gnt_at_addr;
  logic [W-1:0]     a_at_addr;
  logic [1:0]       cmd_at_addr;
  int               cyc;

  initial begin
    addr_seen = 1'b0;
    cyc       = 0;
    forever begin
      @(negedge CLK);
      cyc++;
      if (!RST) begin
        addr_seen = 1'b0;
        continue;
      end
      check("gnt_onehot0", 32'($onehot0(gnt)), 1);
      check("bus_conflict", 32'(bus_oe && m_rd), 0);
      if (gnt == '0) check("idle_oe", 32'(bus_oe), 0);
      if (done != '0) begin
        int own;
        int k;
        own = 0;
        k   = -1;
        for (int b = 0; b < N_REQ; b++) if (done[b]) own = b;
        check("done_after_addr", 32'(addr_seen), 1);
        check("done_owner", 32'(done), 32'(gnt_at_addr));
        check("gnt_in_data", 32'(gnt), 32'(done));
        check("data_cmd", 32'(mem_cmd), 0);
        for (int j = 0; j < exp_q.size(); j++)
          if (k < 0 && exp_q[j].idx == 8'(own)) k = j;
        if (k < 0) begin
          check("sb_hit", 0, 1);
        end else begin
          txn_t e;
          e = exp_q[k];
          exp_q.delete(k);
          check("sb_addr", 32'(a_at_addr), 32'(e.a));
          check("sb_cmd", 32'(cmd_at_addr), e.we ? 32'd2 : 32'd1);
          if (e.we) begin
            check("wr_oe", 32'(bus_oe), 1);
            check("wr_data", 32'(bus_out), 32'(e.d));
            ref_mem[e.a] = e.d;
          end else begin
            check("rd_oe", 32'(bus_oe), 0);
            check("rd_data", 32'(rdata), 32'(ref_mem[e.a]));
          end
        end
        done_cyc_q.push_back(cyc);
        done_own_q.push_back(own);
      end
      addr_seen = (mem_cmd != 2'b00);
      if (addr_seen) begin
        gnt_at_addr = gnt;
        a_at_addr   = bus_out;
        cmd_at_addr = mem_cmd;
        check("addr_oe", 32'(bus_oe), 1);
        check("addr_cmd_legal", 32'(mem_cmd == 2'b11), 0);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_done(input int i, input string tag);
    int b;
    b = 0;
    do begin
      @(negedge CLK);
      b++;
    end while (!done[i] && b < 100);
    check(tag, 32'(done[i]), 1);
  endtask

  // Issues n transactions from requester i; with gap 0 req stays high between them.
  task automatic agent(input int i, input int n, input int gap_max, input logic fix_we,
                       input logic [W-1:0] fix_a, input logic [W-1:0] fix_d, input bit rnd);
    for (int k = 0; k < n; k++) begin
      txn_t t;
      int   gap;
      t.idx = 8'(i);
      if (rnd) begin
        t.we = 1'($urandom_range(0, 1));
        t.a  = 8'($urandom_range(0, 15));
        t.d  = 8'($urandom);
      end else begin
        t.we = fix_we;
        t.a  = fix_a + 8'(k);
        t.d  = fix_d + 8'(k);
      end
      we[i]          = t.we;
      addr[i*W +: W] = t.a;
      wdata[i*W +: W] = t.d;
      exp_q.push_back(t);
      req[i] = 1'b1;
      wait_done(i, $sformatf("agent%0d_done", i));
      if (!done[i]) begin
        req[i] = 1'b0;
        return;
      end
      @(posedge CLK);
      #1;
      gap = rnd ? $urandom_range(0, gap_max) : 0;
      if (gap > 0 || k == n - 1) begin
        req[i] = 1'b0;
        repeat (gap) @(posedge CLK);
        #1;
      end
    end
    req[i] = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    txn_t t;
    RST   = 1'b0;
    req   = '0;
    we    = '0;
    addr  = '0;
    wdata = '0;
    init_ref();
    #12;
    check("rst_gnt", 32'(gnt), 0);
    check("rst_done", 32'(done), 0);
    check("rst_cmd", 32'(mem_cmd), 0);
    check("rst_oe", 32'(bus_oe), 0);
    check("rst_bus_out", 32'(bus_out), 0);
    @(negedge CLK) RST = 1'b1;
    @(posedge CLK);
    #1;

    // Single read from requester 0.
    we[0] = 1'b0; addr[0 +: W] = 8'h3C;
    t = '{idx: 8'd0, we: 1'b0, a: 8'h3C, d: 8'h00};
    exp_q.push_back(t);
    req = 2'b01;
    @(negedge CLK);
    check("t1_idle_gnt", 32'(gnt), 0);
    @(negedge CLK);
    check("t1_gnt", 32'(gnt), 32'b01);
    check("t1_addr", 32'(bus_out), 32'h3C);
    check("t1_cmd", 32'(mem_cmd), 32'b01);
    check("t1_addr_oe", 32'(bus_oe), 1);
    @(negedge CLK);
    check("t1_done", 32'(done), 32'b01);
    check("t1_rdata", 32'(rdata), 32'hA5);
    check("t1_data_oe", 32'(bus_oe), 0);
    @(posedge CLK);
    #1 req = 2'b00;
    @(negedge CLK);
    check("t1_ret_gnt", 32'(gnt), 0);
    check("t1_ret_oe", 32'(bus_oe), 0);

    // Single write from requester 1.
    @(posedge CLK);
    #1;
    we[1] = 1'b1; addr[W +: W] = 8'h10; wdata[W +: W] = 8'h77;
    t = '{idx: 8'd1, we: 1'b1, a: 8'h10, d: 8'h77};
    exp_q.push_back(t);
    req = 2'b10;
    @(negedge CLK);
    @(negedge CLK);
    check("t2_gnt", 32'(gnt), 32'b10);
    check("t2_addr", 32'(bus_out), 32'h10);
    check("t2_cmd", 32'(mem_cmd), 32'b10);
    @(negedge CLK);
    check("t2_done", 32'(done), 32'b10);
    check("t2_wdata", 32'(bus_out), 32'h77);
    check("t2_oe", 32'(bus_oe), 1);
    @(posedge CLK);
    #1 req = 2'b00;
    @(posedge CLK);
    #1;
    check("t2_mem", 32'(mem[8'h10]), 32'h77);
    agent(0, 1, 0, 1'b0, 8'h10, 8'h00, 1'b0);

    // Contention: both requesters held; grants alternate with no idle gap.
    done_cyc_q.delete(); done_own_q.delete();
    fork
      agent(0, 4, 0, 1'b0, 8'h20, 8'h00, 1'b0);
      agent(1, 4, 0, 1'b1, 8'h28, 8'hC3, 1'b0);
    join
    check("t3_count", 32'(done_own_q.size()), 8);
    for (int k = 0; k < done_own_q.size(); k++) begin
      check($sformatf("t3_owner%0d", k), 32'(done_own_q[k]), 32'(k % 2));
      if (k > 0) check($sformatf("t3_gap%0d", k), 32'(done_cyc_q[k] - done_cyc_q[k-1]), 2);
    end
    repeat (2) @(posedge CLK);
    #1;

    // Lone repeater: one transaction every 3 cycles.
    done_cyc_q.delete(); done_own_q.delete();
    agent(0, 4, 0, 1'b0, 8'h05, 8'h00, 1'b0);
    check("t4_count", 32'(done_cyc_q.size()), 4);
    for (int k = 1; k < done_cyc_q.size(); k++)
      check($sformatf("t4_gap%0d", k), 32'(done_cyc_q[k] - done_cyc_q[k-1]), 3);
    repeat (2) @(posedge CLK);
    #1;

    // Reset during requester 1's address phase.
    we = 2'b00; addr[0 +: W] = 8'h30; addr[W +: W] = 8'h31;
    t = '{idx: 8'd0, we: 1'b0, a: 8'h30, d: 8'h00}; exp_q.push_back(t);
    t = '{idx: 8'd1, we: 1'b0, a: 8'h31, d: 8'h00}; exp_q.push_back(t);
    req = 2'b11;
    wait_done(0, "t5_first_done");
    @(posedge CLK);
    #1;
    t = '{idx: 8'd0, we: 1'b0, a: 8'h30, d: 8'h00}; exp_q.push_back(t);
    @(negedge CLK);
    check("t5_pre_gnt", 32'(gnt), 32'b10);
    check("t5_pre_cmd", 32'(mem_cmd), 32'b01);
    #2 RST = 1'b0;
    init_ref();
    #1;
    check("t5_rst_oe", 32'(bus_oe), 0);
    check("t5_rst_gnt", 32'(gnt), 0);
    check("t5_rst_cmd", 32'(mem_cmd), 0);
    check("t5_rst_done", 32'(done), 0);
    @(negedge CLK);
    check("t5_no_done", 32'(done), 0);
    #1 RST = 1'b1;
    @(negedge CLK);
    check("t5_regrant", 32'(gnt), 32'b01);
    wait_done(0, "t5_done0");
    @(posedge CLK);
    #1 req[0] = 1'b0;
    wait_done(1, "t5_done1");
    @(posedge CLK);
    #1 req[1] = 1'b0;
    repeat (2) @(posedge CLK);
    #1;

    // Random traffic from both requesters.
    fork
      agent(0, 150, 3, 1'b0, 8'h00, 8'h00, 1'b1);
      agent(1, 150, 3, 1'b0, 8'h00, 8'h00, 1'b1);
    join
    repeat (3) @(posedge CLK);
    check("sb_empty", 32'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
